tlc_monitor: RTL and testbench
==============================

TLC_MONITOR -- requirements
Module: tlc_monitor

Interface
REQ-001 Parameters, each given as name, default, meaning:
- DWELL_MIN, 7: minimum legal cycles per lit phase.
- DWELL_MAX, 7: maximum legal cycles per lit phase.
- CW, 8: dwell counter width.
REQ-002 Ports, each given as name, direction, width, meaning:
- clk, in, 1: clock.
- rst, in, 1: reset, asynchronous, active-high.
REQ-003 clr, in, 1: synchronous clear of err_any, cycles and locked.
REQ-004 r, y, g, in, 1 each: observed lamp drives from the light controller.
REQ-005 phase, out, 3: monitor state. 0=OFF, 1=RED, 2=YEL, 3=GRN, 4=FAULT.
REQ-006 dwell, out, CW: cycles the current phase has been observed, including the entry cycle.
REQ-007 err_combo, err_seq, err_short, err_long, out, 1 each: single-cycle error pulses.
REQ-008 err_any, out, 1: sticky OR of all error pulses.
REQ-009 cycles, out, 16: count of completed RED->YEL->GRN->RED cycles; wraps modulo 2^16.
REQ-010 locked, out, 1: high once one full legal cycle has completed since the last OFF or FAULT exit.

Function
REQ-011 {r,y,g} shall be registered once (sample stage) every clk; all decisions use the sampled vector.
REQ-012 Sampled vector decode:
- 000 = OFF.
- exactly one bit set = RED, YEL or GRN.
- two or more bits set = BAD.
REQ-013 Latency: a lamp change at an input edge is reflected in phase and error pulses two clk edges later (sample, then state update).
REQ-014 Legal successors: OFF->RED, RED->YEL, YEL->GRN, GRN->RED.
REQ-015 Sampled phase equals current state (RED/YEL/GRN): dwell increments, saturating at 2^CW-1.
REQ-016 err_long shall pulse exactly once per phase, on the cycle dwell becomes DWELL_MAX+1.
REQ-017 Legal successor observed:
- err_short pulses if dwell < DWELL_MIN.
- state advances; dwell loads 1.
REQ-018 On GRN->RED, cycles increments and locked sets.
REQ-019 Lit state observing any non-successor other than itself, including OFF: err_seq pulses; state goes to FAULT; dwell loads 1; locked clears.
REQ-020 BAD observed in any state: err_combo pulses; state goes to FAULT; locked clears. BAD takes priority over err_seq; only one of these two pulses in a cycle.
REQ-021 In OFF:
- OFF holds, dwell counts.
- RED enters RED with dwell=1.
- YEL or GRN gives err_seq and FAULT.
REQ-022 In FAULT:
- dwell counts.
- sampled RED (clean) enters RED with dwell=1, no error pulse.
- sampled OFF enters OFF.
- all other inputs hold FAULT with no further pulses.
REQ-023 err_any sets on any error pulse and holds until rst or clr.
REQ-024 clr coincident with an error pulse: the error wins and err_any stays 1.
REQ-025 clr shall not alter phase or dwell.
REQ-026 err_short and err_seq cannot coincide. err_long and a transition in the same cycle: the transition is taken and err_long is suppressed.

Reset
REQ-027 On rst, asynchronously:
- phase=OFF; dwell=0; cycles=0.
- all err_* outputs=0; err_any=0; locked=0.
- sample register=000.
REQ-028 rst asserted mid-phase abandons the phase silently; no error pulse on or after release.
REQ-029 After rst release, the first sampled RED is treated per REQ-021.

Structure
REQ-030 Shared package tlc_pkg shall hold:
- the phase encoding constants (OFF/RED/YEL/GRN/FAULT).
- the lamp-vector decode constants, also used by the controller.
REQ-031 Sub-module tlc_lamp_decode shall map the 3-bit lamp vector to {OFF, RED, YEL, GRN, BAD}.
REQ-032 The FSM, dwell counter, cycle counter and flags reside in tlc_monitor.

Verification
REQ-033 Reset, then OFF 3 cycles, R7, Y7, G7, R1 -> no err pulses; cycles=1 and locked=1 two edges after R appears.
REQ-034 R held 5 cycles, then Y -> err_short pulses one cycle; phase=YEL; dwell=1; err_any=1.
REQ-035 R held 9 cycles -> err_long pulses once when dwell=8; no second pulse at dwell=9.
REQ-036 In YEL, drive r=1,g=1 -> err_combo pulses; phase=FAULT; locked=0. Then drive R alone -> phase=RED, no pulse.
REQ-037 R7 then G -> err_seq pulses; phase=FAULT. clr with no new error -> err_any=0; cycles=0.
REQ-038 Assert rst mid-YEL at dwell=4 -> all outputs 0 immediately without a clk edge. Release, then R -> phase=RED two edges later.

Source files
------------

// File: rtl/tlc_pkg.sv
// Shared traffic-light definitions: monitor phase encoding, lamp vector
// constants and the decoded lamp classification.
package tlc_pkg;

  typedef enum logic [2:0] {
    PH_OFF   = 3'd0,
    PH_RED   = 3'd1,
    PH_YEL   = 3'd2,
    PH_GRN   = 3'd3,
    PH_FAULT = 3'd4
  } phase_e;

  typedef enum logic [2:0] {
    LV_OFF = 3'd0,
    LV_RED = 3'd1,
    LV_YEL = 3'd2,
    LV_GRN = 3'd3,
    LV_BAD = 3'd4
  } lamp_e;

  // Lamp vectors are packed as {r, y, g}.
  localparam logic [2:0] LAMP_OFF = 3'b000;
  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;

  function automatic phase_e lamp_to_phase(lamp_e kind);
    case (kind)
      LV_RED:  return PH_RED;
      LV_YEL:  return PH_YEL;
      LV_GRN:  return PH_GRN;
      default: return PH_OFF;
    endcase
  endfunction

  function automatic phase_e successor(phase_e p);
    case (p)
      PH_RED:  return PH_YEL;
      PH_YEL:  return PH_GRN;
      PH_GRN:  return PH_RED;
      default: return PH_RED;
    endcase
  endfunction

endpackage

// File: rtl/tlc_lamp_decode.sv
// Classifies a sampled {r,y,g} lamp vector as OFF, a single lit lamp, or BAD.
module tlc_lamp_decode
  import tlc_pkg::*;
(
  input  logic [2:0] lamp_i,
  output logic [2:0] kind_o
);

  always_comb begin
    case (lamp_i)
      LAMP_OFF: kind_o = LV_OFF;
      LAMP_RED: kind_o = LV_RED;
      LAMP_YEL: kind_o = LV_YEL;
      LAMP_GRN: kind_o = LV_GRN;
      default:  kind_o = LV_BAD;
    endcase
  end

endmodule

// File: rtl/tlc_monitor.sv
// Traffic-light sequence monitor: samples the lamp drives, tracks the phase
// and its dwell, and flags illegal combinations, orders and dwell times.
module tlc_monitor
  import tlc_pkg::*;
#(
  parameter int DWELL_MIN = 7,
  parameter int DWELL_MAX = 7,
  parameter int CW        = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          r,
  input  logic          y,
  input  logic          g,
  output logic [2:0]    phase,
  output logic [CW-1:0] dwell,
  output logic          err_combo,
  output logic          err_seq,
  output logic          err_short,
  output logic          err_long,
  output logic          err_any,
  output logic [15:0]   cycles,
  output logic          locked
);

  localparam logic [CW-1:0] DWELL_SAT = '1;
  localparam logic [CW-1:0] MIN_C     = CW'(DWELL_MIN);
  localparam logic [CW-1:0] MAX_C     = CW'(DWELL_MAX);
  localparam logic [CW-1:0] ONE_C     = CW'(1);

  logic [2:0]    lamp_q;
  logic [2:0]    kind_raw;
  lamp_e         kind;
  phase_e        state_q, state_d, seen;
  logic [CW-1:0] dwell_q, dwell_d, dwell_inc;
  logic          combo_q, combo_d, seq_q, seq_d, short_q, short_d, long_q, long_d;
  logic          any_q, any_d, locked_q, locked_d, wrap;
  logic [15:0]   cycles_q, cycles_d;

  tlc_lamp_decode u_decode (
    .lamp_i (lamp_q),
    .kind_o (kind_raw)
  );

  assign kind      = lamp_e'(kind_raw);
  assign seen      = lamp_to_phase(kind);
  assign dwell_inc = (dwell_q == DWELL_SAT) ? dwell_q : dwell_q + ONE_C;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lamp_q   <= LAMP_OFF;
      state_q  <= PH_OFF;
      dwell_q  <= '0;
      combo_q  <= 1'b0;
      seq_q    <= 1'b0;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      any_q    <= 1'b0;
      cycles_q <= '0;
      locked_q <= 1'b0;
    end else begin
      lamp_q   <= {r, y, g};
      state_q  <= state_d;
      dwell_q  <= dwell_d;
      combo_q  <= combo_d;
      seq_q    <= seq_d;
      short_q  <= short_d;
      long_q   <= long_d;
      any_q    <= any_d;
      cycles_q <= cycles_d;
      locked_q <= locked_d;
    end
  end

  // BAD outranks every sequencing decision; FAULT swallows everything except
  // a clean RED or OFF, so it never re-fires pulses while it waits.
  always_comb begin
    state_d = state_q;
    dwell_d = dwell_inc;
    combo_d = 1'b0;
    seq_d   = 1'b0;
    short_d = 1'b0;
    long_d  = 1'b0;
    wrap    = 1'b0;
    if (kind == LV_BAD && state_q != PH_FAULT) begin
      combo_d = 1'b1;
      state_d = PH_FAULT;
      dwell_d = ONE_C;
    end else begin
      case (state_q)
        PH_OFF: begin
          if (kind == LV_RED) begin
            state_d = PH_RED;
            dwell_d = ONE_C;
          end else if (kind != LV_OFF) begin
            seq_d   = 1'b1;
            state_d = PH_FAULT;
            dwell_d = ONE_C;
          end
        end
        PH_FAULT: begin
          if (kind == LV_RED) begin
            state_d = PH_RED;
            dwell_d = ONE_C;
          end else if (kind == LV_OFF) begin
            state_d = PH_OFF;
            dwell_d = ONE_C;
          end
        end
        default: begin
          if (seen == state_q) begin
            long_d = (dwell_q == MAX_C) && (MAX_C != DWELL_SAT);
          end else if (seen == successor(state_q)) begin
            short_d = (dwell_q < MIN_C);
            state_d = successor(state_q);
            dwell_d = ONE_C;
            wrap    = (state_q == PH_GRN);
          end else begin
            seq_d   = 1'b1;
            state_d = PH_FAULT;
            dwell_d = ONE_C;
          end
        end
      endcase
    end
    any_d    = combo_d | seq_d | short_d | long_d | (any_q & ~clr);
    cycles_d = clr ? 16'd0 : cycles_q + {15'd0, wrap};
    if (clr || combo_d || seq_d) begin
      locked_d = 1'b0;
    end else if (wrap) begin
      locked_d = 1'b1;
    end else begin
      locked_d = locked_q;
    end
  end

  always_comb begin
    phase     = state_q;
    dwell     = dwell_q;
    err_combo = combo_q;
    err_seq   = seq_q;
    err_short = short_q;
    err_long  = long_q;
    err_any   = any_q;
    cycles    = cycles_q;
    locked    = locked_q;
  end

endmodule

// File: tb/tb_tlc_monitor.sv
// Directed self-checking bench for tlc_monitor with hand-computed expectations.
module tb_tlc_monitor;

  localparam logic [2:0] L_OFF = 3'b000;
  localparam logic [2:0] L_R   = 3'b100;
  localparam logic [2:0] L_Y   = 3'b010;
  localparam logic [2:0] L_G   = 3'b001;
  localparam logic [2:0] L_RG  = 3'b101;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        r = 1'b0, y = 1'b0, g = 1'b0;
  logic [2:0]  phase;
  logic [7:0]  dwell;
  logic        err_combo, err_seq, err_short, err_long, err_any, locked;
  logic [15:0] cycles;

  int tests = 0;
  int fails = 0;
  int nCombo = 0, nSeq = 0, nShort = 0, nLong = 0;

  tlc_monitor #(.DWELL_MIN(7), .DWELL_MAX(7), .CW(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .r         (r),
    .y         (y),
    .g         (g),
    .phase     (phase),
    .dwell     (dwell),
    .err_combo (err_combo),
    .err_seq   (err_seq),
    .err_short (err_short),
    .err_long  (err_long),
    .err_any   (err_any),
    .cycles    (cycles),
    .locked    (locked)
  );

  always #5 clk = ~clk;

  // Pulse tallies, taken just after each edge so every single-cycle pulse counts once.
  always @(posedge clk) begin
    #1;
    if (err_combo === 1'b1) nCombo++;
    if (err_seq === 1'b1) nSeq++;
    if (err_short === 1'b1) nShort++;
    if (err_long === 1'b1) nLong++;
  end

  function automatic int totalPulses();
    return nCombo + nSeq + nShort + nLong;
  endfunction

  task automatic drive(input logic [2:0] lamp, input int n);
    {r, y, g} = lamp;
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic doReset();
    {r, y, g} = L_OFF;
    clr = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    {r, y, g} = L_R;
    @(negedge clk);
    tests++;
    if ({phase, dwell, cycles, err_any, locked} !== 29'd0) begin
      fails++;
      $display("[TB] FAIL reset_state got phase=%0d dwell=%0d cycles=%0d any=%b locked=%b required all 0",
               phase, dwell, cycles, err_any, locked);
    end
    tests++;
    if ({err_combo, err_seq, err_short, err_long} !== 4'b0000) begin
      fails++;
      $display("[TB] FAIL reset_pulses got %b required 0000", {err_combo, err_seq, err_short, err_long});
    end
    doReset();
  endtask

  task automatic test_nominal();
    int base;
    doReset();
    base = totalPulses();
    drive(L_OFF, 3);
    drive(L_R, 7);
    tests++;
    if (phase !== 3'd1 || dwell !== 8'd6) begin
      fails++;
      $display("[TB] FAIL nominal_red got phase=%0d dwell=%0d required phase=1 dwell=6", phase, dwell);
    end
    drive(L_Y, 7);
    drive(L_G, 7);
    drive(L_R, 2);
    tests++;
    if (cycles !== 16'd1 || locked !== 1'b1) begin
      fails++;
      $display("[TB] FAIL nominal_wrap got cycles=%0d locked=%b required cycles=1 locked=1", cycles, locked);
    end
    tests++;
    if (phase !== 3'd1 || dwell !== 8'd1) begin
      fails++;
      $display("[TB] FAIL nominal_reenter got phase=%0d dwell=%0d required phase=1 dwell=1", phase, dwell);
    end
    tests++;
    if (totalPulses() - base !== 0 || err_any !== 1'b0) begin
      fails++;
      $display("[TB] FAIL nominal_quiet got pulses=%0d any=%b required pulses=0 any=0",
               totalPulses() - base, err_any);
    end
  endtask

  task automatic test_short();
    doReset();
    drive(L_R, 5);
    drive(L_Y, 2);
    tests++;
    if (err_short !== 1'b1 || phase !== 3'd2 || dwell !== 8'd1 || err_any !== 1'b1) begin
      fails++;
      $display("[TB] FAIL short_pulse got short=%b phase=%0d dwell=%0d any=%b required 1/2/1/1",
               err_short, phase, dwell, err_any);
    end
    drive(L_Y, 1);
    tests++;
    if (err_short !== 1'b0) begin
      fails++;
      $display("[TB] FAIL short_single got short=%b required 0", err_short);
    end
  endtask

  task automatic test_long();
    int base;
    doReset();
    base = nLong;
    drive(L_R, 8);
    tests++;
    if (err_long !== 1'b0 || dwell !== 8'd7) begin
      fails++;
      $display("[TB] FAIL long_at7 got long=%b dwell=%0d required long=0 dwell=7", err_long, dwell);
    end
    drive(L_R, 1);
    tests++;
    if (err_long !== 1'b1 || dwell !== 8'd8) begin
      fails++;
      $display("[TB] FAIL long_at8 got long=%b dwell=%0d required long=1 dwell=8", err_long, dwell);
    end
    drive(L_R, 3);
    tests++;
    if (nLong - base !== 1 || err_any !== 1'b1 || dwell !== 8'd11) begin
      fails++;
      $display("[TB] FAIL long_once got pulses=%0d any=%b dwell=%0d required 1/1/11",
               nLong - base, err_any, dwell);
    end
  endtask

  task automatic test_combo();
    int base;
    doReset();
    drive(L_R, 7);
    drive(L_Y, 7);
    drive(L_G, 7);
    drive(L_R, 7);
    drive(L_Y, 3);
    tests++;
    if (phase !== 3'd2 || locked !== 1'b1) begin
      fails++;
      $display("[TB] FAIL combo_pre got phase=%0d locked=%b required phase=2 locked=1", phase, locked);
    end
    drive(L_RG, 2);
    tests++;
    if (err_combo !== 1'b1 || err_seq !== 1'b0 || phase !== 3'd4 || locked !== 1'b0) begin
      fails++;
      $display("[TB] FAIL combo_fault got combo=%b seq=%b phase=%0d locked=%b required 1/0/4/0",
               err_combo, err_seq, phase, locked);
    end
    base = totalPulses();
    drive(L_R, 2);
    tests++;
    if (phase !== 3'd1 || dwell !== 8'd1 || totalPulses() - base !== 0) begin
      fails++;
      $display("[TB] FAIL combo_recover got phase=%0d dwell=%0d pulses=%0d required 1/1/0",
               phase, dwell, totalPulses() - base);
    end
  endtask

  task automatic test_seq_clr();
    doReset();
    drive(L_R, 7);
    drive(L_Y, 7);
    drive(L_G, 7);
    drive(L_R, 2);
    drive(L_R, 5);
    drive(L_G, 2);
    tests++;
    if (err_seq !== 1'b1 || err_short !== 1'b0 || phase !== 3'd4 || dwell !== 8'd1) begin
      fails++;
      $display("[TB] FAIL seq_fault got seq=%b short=%b phase=%0d dwell=%0d required 1/0/4/1",
               err_seq, err_short, phase, dwell);
    end
    tests++;
    if (locked !== 1'b0 || cycles !== 16'd1 || err_any !== 1'b1) begin
      fails++;
      $display("[TB] FAIL seq_flags got locked=%b cycles=%0d any=%b required 0/1/1", locked, cycles, err_any);
    end
    clr = 1'b1;
    drive(L_G, 1);
    clr = 1'b0;
    tests++;
    if (err_any !== 1'b0 || cycles !== 16'd0 || phase !== 3'd4 || dwell !== 8'd2) begin
      fails++;
      $display("[TB] FAIL seq_clr got any=%b cycles=%0d phase=%0d dwell=%0d required 0/0/4/2",
               err_any, cycles, phase, dwell);
    end
  endtask

  task automatic test_clr_vs_err();
    doReset();
    drive(L_R, 3);
    drive(L_Y, 1);
    clr = 1'b1;
    drive(L_Y, 1);
    clr = 1'b0;
    tests++;
    if (err_short !== 1'b1 || err_any !== 1'b1 || phase !== 3'd2 || dwell !== 8'd1) begin
      fails++;
      $display("[TB] FAIL clr_vs_err got short=%b any=%b phase=%0d dwell=%0d required 1/1/2/1",
               err_short, err_any, phase, dwell);
    end
  endtask

  task automatic test_rst_mid();
    int base;
    doReset();
    drive(L_R, 7);
    drive(L_Y, 7);
    drive(L_G, 7);
    drive(L_R, 7);
    drive(L_Y, 5);
    tests++;
    if (phase !== 3'd2 || dwell !== 8'd4 || cycles !== 16'd1) begin
      fails++;
      $display("[TB] FAIL rst_mid_pre got phase=%0d dwell=%0d cycles=%0d required 2/4/1", phase, dwell, cycles);
    end
    base = totalPulses();
    #2;
    rst = 1'b1;
    #1;
    tests++;
    if ({phase, dwell, cycles, err_any, locked, err_combo, err_seq, err_short, err_long} !== 33'd0) begin
      fails++;
      $display("[TB] FAIL rst_async got phase=%0d dwell=%0d cycles=%0d locked=%b required all 0",
               phase, dwell, cycles, locked);
    end
    {r, y, g} = L_OFF;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    drive(L_R, 2);
    tests++;
    if (phase !== 3'd1 || dwell !== 8'd1 || totalPulses() - base !== 0 || err_any !== 1'b0) begin
      fails++;
      $display("[TB] FAIL rst_release got phase=%0d dwell=%0d pulses=%0d any=%b required 1/1/0/0",
               phase, dwell, totalPulses() - base, err_any);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_short();
    test_long();
    test_combo();
    test_seq_clr();
    test_clr_vs_err();
    test_rst_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
